// File: rtl/alu_reg_sequencer.sv
// Issue/writeback sequencer: 8x8 register file feeding the ALU, writes back Res and flags.
// Latency: accept at edge N, writeback at edge N+ALU_WAIT, done during the following cycle.
// Backpressure: instr_ready is low for the whole EXEC phase; instr_valid is ignored while busy.
module alu_reg_sequencer #(
   parameter int ALU_WAIT = 1,
   parameter int NREG     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [2:0] instr_op,
   input  logic [2:0] instr_rd,
   input  logic [2:0] instr_rs1,
   input  logic [2:0] instr_rs2,
   input  logic       ld_en,
   input  logic [2:0] ld_addr,
   input  logic [7:0] ld_data,
   input  logic [2:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [2:0] Opcode,
   output logic [7:0] Op1,
   output logic [7:0] Op2,
   input  logic [7:0] Res,
   input  logic       C,
   input  logic       AC,
   input  logic       Z,
   input  logic       S,
   output logic [3:0] flags,
   output logic       busy,
   output logic       done
);

   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] EXEC      = 1'b1;
   localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

   logic [0:0] state;
   logic [3:0] cnt;
   logic [2:0] rd_q;
   logic [7:0] rf [NREG];
   logic       accept;
   logic       wb;

   assign instr_ready = (state == IDLE) && rst_n;
   assign busy        = (state == EXEC);
   assign accept      = instr_valid && instr_ready;
   assign wb          = (state == EXEC) && (cnt == 4'd0);
   assign rd_data     = rf[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         rd_q   <= 3'd0;
         Opcode <= 3'd0;
         Op1    <= 8'h00;
         Op2    <= 8'h00;
         flags  <= 4'd0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  Opcode <= instr_op;
                  Op1    <= rf[instr_rs1];
                  Op2    <= rf[instr_rs2];
                  rd_q   <= instr_rd;
                  cnt    <= WAIT_INIT;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  flags <= {S, Z, AC, C};
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A writeback to the same register takes priority over a direct load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= 8'h00;
      end else begin
         if (ld_en && !(wb && (ld_addr == rd_q))) rf[ld_addr] <= ld_data;
         if (wb) rf[rd_q] <= Res;
      end
   end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with an ALU stub and a writeback scoreboard.
module tb_alu_reg_sequencer;

   localparam int ALU_WAIT = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op, instr_rd, instr_rs1, instr_rs2;
   logic       ld_en;
   logic [2:0] ld_addr;
   logic [7:0] ld_data;
   logic [2:0] rd_addr;
   logic [7:0] rd_data;
   logic [2:0] Opcode;
   logic [7:0] Op1, Op2;
   logic [7:0] Res;
   logic       C, AC, Z, S;
   logic [3:0] flags;
   logic       busy, done;

   typedef struct {
      logic [2:0] rd;
      logic [7:0] res;
      logic [3:0] flg;
   } exp_t;

   exp_t sb[$];
   time  acc_t[$];
   int   total = 0;
   int   bad   = 0;

   alu_reg_sequencer #(.ALU_WAIT(ALU_WAIT), .NREG(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .Opcode(Opcode), .Op1(Op1), .Op2(Op2),
      .Res(Res), .C(C), .AC(AC), .Z(Z), .S(S),
      .flags(flags), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic rf_chk(input logic [2:0] a, input logic [7:0] v, input string tag);
      rd_addr = a;
      #1;
      chk(tag, rd_data, v);
   endtask

   task automatic load(input logic [2:0] a, input logic [7:0] v);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = v;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   // ldmode: 0 none, 1 load on the accept edge, 2 load on the writeback edge.
   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] res, input logic [3:0] flg,
                        input logic [7:0] e1, input logic [7:0] e2, input int ldmode,
                        input logic [2:0] la, input logic [7:0] lv, input bit keep);
      int   n;
      exp_t e;
      instr_valid = 1'b1;
      instr_op    = op;
      instr_rd    = rd;
      instr_rs1   = rs1;
      instr_rs2   = rs2;
      Res         = ~res;
      {S, Z, AC, C} = ~flg;
      if (ldmode == 1) begin
         ld_en = 1'b1; ld_addr = la; ld_data = lv;
      end
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_at_issue", 8'(instr_ready), 8'd1);
      acc_t.push_back($time);
      e.rd = rd; e.res = res; e.flg = flg;
      sb.push_back(e);
      @(negedge clk);
      ld_en = 1'b0;
      for (int i = 0; i < ALU_WAIT; i++) begin
         chk("opcode_hold", 8'(Opcode), 8'(op));
         chk("op1_hold", Op1, e1);
         chk("op2_hold", Op2, e2);
         chk("busy_exec", 8'(busy), 8'd1);
         chk("ready_low", 8'(instr_ready), 8'd0);
         chk("done_low", 8'(done), 8'd0);
         if (i == ALU_WAIT - 1) begin
            Res = res;
            {S, Z, AC, C} = flg;
            if (ldmode == 2) begin
               ld_en = 1'b1; ld_addr = la; ld_data = lv;
            end
         end
         @(negedge clk);
      end
      ld_en = 1'b0;
      if (!keep) instr_valid = 1'b0;
      Res = ~res;
      {S, Z, AC, C} = ~flg;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_pulse", 8'(done), 8'd1);
      chk("ready_after_wb", 8'(instr_ready), 8'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("flags_wb", 8'(flags), 8'(e.flg));
         rf_chk(e.rd, e.res, "rf_wb");
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      rst_n = 1'b0; instr_valid = 1'b0;
      instr_op = 3'd0; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
      ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'h00; rd_addr = 3'd0;
      Res = 8'h00; C = 1'b0; AC = 1'b0; Z = 1'b0; S = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 8'(instr_ready), 8'd0);
      chk("rst_flags", 8'(flags), 8'd0);
      chk("rst_opcode", 8'(Opcode), 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 8'(instr_ready), 8'd1);
      chk("idle_busy", 8'(busy), 8'd0);
      chk("idle_done", 8'(done), 8'd0);
      for (int a = 0; a < 8; a++) rf_chk(3'(a), 8'h00, "rst_rf");
      @(negedge clk);

      // Basic op
      load(3'd1, 8'h0F);
      load(3'd2, 8'h01);
      rf_chk(3'd1, 8'h0F, "ld_r1");
      issue(3'd2, 3'd3, 3'd1, 3'd2, 8'h10, 4'b0010, 8'h0F, 8'h01, 0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", 8'(done), 8'd0);

      // Aliasing rd == rs1 == rs2
      load(3'd4, 8'hF8);
      issue(3'd1, 3'd4, 3'd4, 3'd4, 8'hF0, 4'b1001, 8'hF8, 8'hF8, 0, 3'd0, 8'h00, 1'b0);
      @(negedge clk);

      // Back-to-back with valid held; writeback-edge loads (same and other register)
      acc_t.delete();
      issue(3'd3, 3'd5, 3'd1, 3'd2, 8'h55, 4'b0001, 8'h0F, 8'h01, 2, 3'd5, 8'hAA, 1'b1);
      issue(3'd4, 3'd7, 3'd3, 3'd4, 8'h00, 4'b0100, 8'h10, 8'hF0, 2, 3'd6, 8'h77, 1'b0);
      gap = (acc_t.size() >= 2) ? int'((acc_t[1] - acc_t[0]) / 10) : 0;
      chk("accept_gap", 8'(gap), 8'(ALU_WAIT + 1));
      rf_chk(3'd5, 8'h55, "wb_beats_load");
      rf_chk(3'd6, 8'h77, "load_other_reg");
      rf_chk(3'd7, 8'h00, "zero_result");
      @(negedge clk);

      // Load on the accept edge: operand sees the old value; flags fully replaced
      issue(3'd5, 3'd2, 3'd1, 3'd2, 8'h3C, 4'b1000, 8'h0F, 8'h01, 1, 3'd1, 8'h22, 1'b0);
      rf_chk(3'd1, 8'h22, "accept_load");
      @(negedge clk);

      // Reset mid-EXEC aborts the writeback
      instr_valid = 1'b1; instr_op = 3'd6; instr_rd = 3'd3; instr_rs1 = 3'd3; instr_rs2 = 3'd4;
      Res = 8'h99; {S, Z, AC, C} = 4'hF;
      @(negedge clk);
      instr_valid = 1'b0;
      chk("busy_before_rst", 8'(busy), 8'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 8'(instr_ready), 8'd0);
      chk("mid_rst_busy", 8'(busy), 8'd0);
      chk("mid_rst_flags", 8'(flags), 8'd0);
      chk("mid_rst_opcode", 8'(Opcode), 8'd0);
      chk("mid_rst_op1", Op1, 8'h00);
      chk("mid_rst_op2", Op2, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 8'(instr_ready), 8'd1);
      repeat (ALU_WAIT + 1) @(negedge clk);
      chk("post_rst_done", 8'(done), 8'd0);
      chk("post_rst_flags", 8'(flags), 8'd0);
      for (int a = 0; a < 8; a++) rf_chk(3'(a), 8'h00, "post_rst_rf");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_reg_sequencer.md
Name: alu_reg_sequencer

Overview:
Upstream issue/writeback stage for the 8-bit ALU. Holds an 8x8-bit register file and a 4-bit flag register, and accepts 3-operand instructions over a valid/ready handshake. For each instruction it drives the ALU's Opcode/Op1/Op2 inputs from the register file, waits a fixed settle time, then writes the ALU's Res into the destination register and latches the C/AC/Z/S flags. It is the only driver of the ALU operand ports in the ALU_MEMORY_COMPARATOR datapath.

Parameters:
ALU_WAIT, 1, number of clock cycles Opcode/Op1/Op2 are held stable before writeback; legal range 1..15.
NREG, 8, number of registers; fixed at 8 because register addresses are 3 bits.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr_valid  in  1  instruction present.
instr_ready  out  1  sequencer can accept an instruction.
instr_op  in  3  opcode, passed unmodified to the ALU.
instr_rd  in  3  destination register.
instr_rs1  in  3  source register for Op1.
instr_rs2  in  3  source register for Op2.
ld_en  in  1  direct register load strobe.
ld_addr  in  3  load address.
ld_data  in  8  load data.
rd_addr  in  3  debug read address.
rd_data  out  8  combinational read of rf[rd_addr].
Opcode  out  3  to ALU.
Op1  out  8  to ALU.
Op2  out  8  to ALU.
Res  in  8  from ALU.
C  in  1  carry flag from ALU.
AC  in  1  auxiliary-carry flag from ALU.
Z  in  1  zero flag from ALU.
S  in  1  sign flag from ALU.
flags  out  4  registered {S,Z,AC,C} from the last writeback.
busy  out  1  high while in the EXEC state.
done  out  1  one-cycle pulse after a writeback.

Behaviour:
- Reset (async, rst_n=0): all rf entries 0x00; flags=0; Opcode/Op1/Op2=0; done=0; state=IDLE; wait counter=0. An instruction in flight is aborted with no writeback.
- FSM has two states, IDLE and EXEC. instr_ready = (state==IDLE) && rst_n. busy = (state==EXEC).
- IDLE: on a rising edge with instr_valid && instr_ready:
  - Opcode<=instr_op, Op1<=rf[instr_rs1], Op2<=rf[instr_rs2].
  - rd latched internally; counter<=ALU_WAIT-1; state->EXEC.
- EXEC: Opcode/Op1/Op2 are held constant.
  - When counter!=0: counter decrements each edge.
  - When counter==0 at an edge: rf[rd]<=Res; flags<={S,Z,AC,C}; done<=1 for exactly one cycle; state->IDLE.
- Latency: accept at edge N, writeback at edge N+ALU_WAIT, done high during the following cycle, next accept no earlier than edge N+ALU_WAIT+1. Peak throughput is one instruction per ALU_WAIT+1 cycles.
- Res and flags are sampled only on the writeback edge. ALU outputs in any other cycle are ignored.
- Register read/write hazards:
  - rs1, rs2 and rd may alias, e.g. rd==rs1 (r3 <= r3 op r3 is legal).
  - Operands are read on the accept edge, so a writeback never forwards into the same instruction.
- Loads:
  - ld_en writes rf[ld_addr]<=ld_data on any edge, except when that edge is a writeback edge to the same address. In that case the writeback wins and the load is dropped.
  - A load to a different address on a writeback edge succeeds.
  - A load on an accept edge to a source register: the operand gets the OLD value.
- Outputs in IDLE: Opcode/Op1/Op2 keep the last issued values. done=0.
- instr_valid is ignored while busy. The sender must hold the instruction until it sees instr_ready.
- Width rules: no arithmetic inside this block. Res is stored as 8 bits, unmodified.

Test Plan:
- Reset/idle: assert rst_n=0 mid-EXEC -> no writeback; all rf=0x00, flags=0, Opcode/Op1/Op2=0, instr_ready=1 one cycle after release.
- Basic op: ld r1=0x0F, r2=0x01; issue op=2, rd=3, rs1=1, rs2=2; ALU stub returns Res=0x10, AC=1 -> Op1=0x0F, Op2=0x01, Opcode=2 held ALU_WAIT cycles. Then rf[3]=0x10, flags=4'b0010, a one-cycle done pulse, and rd_data(3)=0x10.
- Latency/throughput with ALU_WAIT=3: two back-to-back instructions with instr_valid held high -> accepts 4 cycles apart; instr_ready low for exactly 3 cycles after each accept.
- Aliasing: r4=0xF8 (-8); issue rd=4, rs1=4, rs2=4; stub Res=0xF0, S=1, C=1 -> Op1=Op2=0xF8, then rf[4]=0xF0, flags=4'b1001.
- Load collisions:
  - Load r5=0xAA on the same edge as a writeback to r5 with Res=0x55 -> rf[5]=0x55.
  - Load r6=0x77 on that edge -> rf[6]=0x77.
  - Load r1=0x22 on an accept edge reading rs1=1 (old 0x0F) -> Op1=0x0F, rf[1]=0x22.
- Zero flag: stub Res=0x00, Z=1 -> rf[rd]=0x00, flags=4'b0100. The next instruction's flags fully replace this value (no accumulation).
